// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, pattern mode encodings and pixel colour type.
// Used by the timing controller and by the pattern generator.
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;

  localparam int BOX_SIZE = 32;
  localparam int STEP     = 2;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb_t RGB_WHITE = '{r: 3'd7, g: 3'd7, b: 2'd3};
  localparam rgb_t RGB_BLUE  = '{r: 3'd0, g: 3'd0, b: 2'd3};

  // Expand a 3-bit bar code into a saturated primary/secondary colour.
  function automatic rgb_t bar_rgb(input logic [2:0] c);
    rgb_t px;
    px.r = {3{c[2]}};
    px.g = {3{c[1]}};
    px.b = {2{c[0]}};
    return px;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: position and direction, stepped once per frame tick.
// Bounces between 0 and LIMIT, clamping to the end stop on the frame it is reached.
module vga_box_mover
  import vga_timing_pkg::*;
#(
  parameter int LIMIT     = H_ACTIVE - BOX_SIZE,
  parameter int RESET_POS = (H_ACTIVE - BOX_SIZE) / 2,
  parameter int STEP_SIZE = STEP
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       tick,
  output logic [9:0] pos,
  output logic       dir_neg
);

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [9:0]  STEP_C  = 10'(STEP_SIZE);

  logic [9:0]  pos_d, pos_q;
  logic        dir_neg_d, dir_neg_q;
  logic [10:0] sum;

  always_comb begin
    pos_d     = pos_q;
    dir_neg_d = dir_neg_q;
    sum       = {1'b0, pos_q} + {1'b0, STEP_C};
    if (tick) begin
      if (!dir_neg_q) begin
        if (sum >= LIMIT_W) begin
          pos_d     = LIMIT_W[9:0];
          dir_neg_d = 1'b1;
        end else begin
          pos_d = sum[9:0];
        end
      end else begin
        if (pos_q <= STEP_C) begin
          pos_d     = '0;
          dir_neg_d = 1'b0;
        end else begin
          pos_d = pos_q - STEP_C;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pos_q     <= 10'(RESET_POS);
      dir_neg_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      dir_neg_q <= dir_neg_d;
    end
  end

  assign pos     = pos_q;
  assign dir_neg = dir_neg_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage after the VGA timing controller: four test patterns, registered
// 3-3-2 RGB with sync delayed by the same single stage.
module vga_pattern_gen
  import vga_timing_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic [9:0] hcounter,
  input  logic [9:0] vcounter,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode,
  input  logic [7:0] solid_rgb,
  output logic [2:0] Red,
  output logic [2:0] Green,
  output logic [1:0] Blue,
  output logic       Hsync,
  output logic       Vsync,
  output logic [7:0] frame_count
);

  logic       frame_tick;
  logic       active;
  logic       in_box;
  logic [2:0] bar_idx;
  logic [9:0] box_x, box_y;
  logic       box_x_neg, box_y_neg;

  mode_e      mode_d, mode_q;
  rgb_t       rgb_d, rgb_q;
  logic       hsync_d, hsync_q;
  logic       vsync_d, vsync_q;
  logic [7:0] frame_count_d, frame_count_q;

  assign frame_tick = (hcounter == 10'(H_TOTAL - 1)) && (vcounter == 10'(V_TOTAL - 1));
  assign active     = (hcounter < 10'(H_ACTIVE)) && (vcounter < 10'(V_ACTIVE));

  vga_box_mover #(
    .LIMIT     (H_ACTIVE - BOX_SIZE),
    .RESET_POS (304),
    .STEP_SIZE (STEP)
  ) u_box_x (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .tick      (frame_tick),
    .pos       (box_x),
    .dir_neg   (box_x_neg)
  );

  vga_box_mover #(
    .LIMIT     (V_ACTIVE - BOX_SIZE),
    .RESET_POS (224),
    .STEP_SIZE (STEP)
  ) u_box_y (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .tick      (frame_tick),
    .pos       (box_y),
    .dir_neg   (box_y_neg)
  );

  // 80-pixel bar index without a divider.
  always_comb begin
    if      (hcounter < 10'd80)  bar_idx = 3'd0;
    else if (hcounter < 10'd160) bar_idx = 3'd1;
    else if (hcounter < 10'd240) bar_idx = 3'd2;
    else if (hcounter < 10'd320) bar_idx = 3'd3;
    else if (hcounter < 10'd400) bar_idx = 3'd4;
    else if (hcounter < 10'd480) bar_idx = 3'd5;
    else if (hcounter < 10'd560) bar_idx = 3'd6;
    else                         bar_idx = 3'd7;
  end

  assign in_box = ({1'b0, hcounter} >= {1'b0, box_x}) &&
                  ({1'b0, hcounter} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                  ({1'b0, vcounter} >= {1'b0, box_y}) &&
                  ({1'b0, vcounter} <  ({1'b0, box_y} + 11'(BOX_SIZE)));

  always_comb begin
    mode_d        = frame_tick ? mode_e'(mode) : mode_q;
    frame_count_d = frame_tick ? frame_count_q + 8'd1 : frame_count_q;
    hsync_d       = hsync_in;
    vsync_d       = vsync_in;
    rgb_d         = RGB_BLACK;
    if (active) begin
      case (mode_q)
        MODE_BARS:  rgb_d = bar_rgb(3'd7 - bar_idx);
        MODE_CHECK: rgb_d = (hcounter[5] ^ vcounter[5]) ? RGB_BLACK : RGB_WHITE;
        MODE_BOX:   rgb_d = in_box ? RGB_WHITE : RGB_BLUE;
        MODE_SOLID: rgb_d = rgb_t'(solid_rgb);
        default:    rgb_d = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      mode_q        <= MODE_BARS;
      rgb_q         <= RGB_BLACK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_count_q <= '0;
    end else begin
      mode_q        <= mode_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign Red         = rgb_q.r;
  assign Green       = rgb_q.g;
  assign Blue        = rgb_q.b;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen; frames are advanced by driving
// the last counter position directly rather than scanning whole frames.
module tb_vga_pattern_gen;

  logic       pixel_clk = 1'b0;
  logic       reset;
  logic [9:0] hcounter;
  logic [9:0] vcounter;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode;
  logic [7:0] solid_rgb;
  logic [2:0] Red;
  logic [2:0] Green;
  logic [1:0] Blue;
  logic       Hsync;
  logic       Vsync;
  logic [7:0] frame_count;

  int n_chk  = 0;
  int n_pass = 0;

  vga_pattern_gen u_dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .hcounter    (hcounter),
    .vcounter    (vcounter),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .Hsync       (Hsync),
    .Vsync       (Vsync),
    .frame_count (frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic int rgb_now();
    return int'({Red, Green, Blue});
  endfunction

  // Drive one pixel position, clock it, then sample just after the edge.
  task automatic step(input int h, input int v, input logic hs = 1'b1, input logic vs = 1'b1);
    hcounter = 10'(h);
    vcounter = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic tick();
    step(799, 524);
  endtask

  int lows;
  int first;

  initial begin
    reset     = 1'b1;
    mode      = 2'd0;
    solid_rgb = 8'h00;

    // Reset with counters running and syncs driven active.
    for (int i = 0; i < 3; i++) step(i, 0, 1'b0, 1'b0);
    chk("reset_rgb", rgb_now(), 0);
    chk("reset_hsync", int'(Hsync), 1);
    chk("reset_vsync", int'(Vsync), 1);
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_box_x", int'(u_dut.u_box_x.pos_q), 304);
    chk("reset_box_y", int'(u_dut.u_box_y.pos_q), 224);
    reset = 1'b0;

    // Colour bars
    tick();
    chk("frame_count_1", int'(frame_count), 1);
    step(0, 10);   chk("bars_0", rgb_now(), 8'hFF);
    step(79, 10);  chk("bars_79", rgb_now(), 8'hFF);
    step(80, 10);  chk("bars_80", rgb_now(), 8'hFC);
    step(160, 10); chk("bars_160", rgb_now(), 8'hE3);
    step(639, 10); chk("bars_639", rgb_now(), 8'h00);
    step(640, 10); chk("bars_640_blank", rgb_now(), 8'h00);
    step(100, 480); chk("bars_v480_blank", rgb_now(), 8'h00);

    // Mode change mid-frame waits for the frame tick
    mode = 2'd1;
    step(320, 100); chk("latch_bars_320", rgb_now(), 8'h1F);
    step(400, 100); chk("latch_bars_400", rgb_now(), 8'h1C);
    tick();
    step(0, 0);   chk("check_0_0", rgb_now(), 8'hFF);
    step(32, 0);  chk("check_32_0", rgb_now(), 8'h00);
    step(32, 32); chk("check_32_32", rgb_now(), 8'hFF);

    // Hsync alignment
    lows = 0; first = -1;
    for (int h = 640; h < 800; h++) begin
      hcounter = 10'(h);
      vcounter = 10'd10;
      hsync_in = !(h >= 656 && h < 752);
      vsync_in = 1'b1;
      #2;
      if (h == 656) chk("hsync_pre_edge", int'(Hsync), 1);
      @(posedge pixel_clk);
      #1;
      if (!Hsync) begin
        lows++;
        if (first < 0) first = h;
      end
    end
    chk("hsync_low_count", lows, 96);
    chk("hsync_first_low", first, 656);
    chk("hsync_end_high", int'(Hsync), 1);

    // Vsync alignment
    lows = 0; first = -1;
    for (int v = 486; v < 496; v++) begin
      hcounter = 10'd700;
      vcounter = 10'(v);
      hsync_in = 1'b1;
      vsync_in = !(v >= 490 && v < 492);
      #2;
      if (v == 490) chk("vsync_pre_edge", int'(Vsync), 1);
      @(posedge pixel_clk);
      #1;
      if (!Vsync) begin
        lows++;
        if (first < 0) first = v;
      end
    end
    chk("vsync_low_count", lows, 2);
    chk("vsync_first_low", first, 490);

    // Bounce from a fresh reset
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(i, 0);
    reset = 1'b0;
    mode  = 2'd2;
    for (int f = 0; f < 152; f++) tick();
    chk("bounce_x_152", int'(u_dut.u_box_x.pos_q), 608);
    chk("bounce_xdir_152", int'(u_dut.u_box_x.dir_neg_q), 1);
    chk("bounce_y_152", int'(u_dut.u_box_y.pos_q), 368);
    step(608, 368); chk("box_top_left", rgb_now(), 8'hFF);
    step(607, 368); chk("box_left_out", rgb_now(), 8'h03);
    step(639, 399); chk("box_bot_right", rgb_now(), 8'hFF);
    step(608, 400); chk("box_below_out", rgb_now(), 8'h03);
    step(608, 367); chk("box_above_out", rgb_now(), 8'h03);
    tick();
    chk("bounce_x_153", int'(u_dut.u_box_x.pos_q), 606);
    step(606, 366); chk("box_moved_in", rgb_now(), 8'hFF);
    step(605, 366); chk("box_moved_out", rgb_now(), 8'h03);
    chk("frame_count_153", int'(frame_count), 153);
    for (int f = 0; f < 102; f++) tick();
    chk("frame_count_255", int'(frame_count), 255);
    tick();
    chk("frame_count_wrap", int'(frame_count), 0);

    // Solid colour, sampled every pixel, then a mid-frame reset
    mode      = 2'd3;
    solid_rgb = 8'hE4;
    tick();
    step(100, 50); chk("solid_E4", rgb_now(), 8'hE4);
    solid_rgb = 8'h1B;
    step(101, 50); chk("solid_1B", rgb_now(), 8'h1B);
    step(700, 50); chk("solid_blank", rgb_now(), 8'h00);
    reset = 1'b1;
    step(400, 200, 1'b0, 1'b0);
    chk("midreset_rgb", rgb_now(), 0);
    chk("midreset_hsync", int'(Hsync), 1);
    chk("midreset_mode_q", int'(u_dut.mode_q), 0);
    reset = 1'b0;
    step(401, 200); chk("after_reset_bars", rgb_now(), 8'h1C);
    chk("after_reset_frame_count", int'(frame_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Pixel-colour stage sitting directly downstream of the VGA timing controller. It consumes the raw `hcounter`/`vcounter` position and the `hsync`/`vsync` pulses, and produces registered 3-3-2 RGB with sync outputs delayed to match. It offers four selectable test patterns, one of which is a frame-animated bouncing box. Its outputs drive the VGA pins directly at 640x480, 800x525 total.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `H_TOTAL`, 800, pixel clocks per line; last `hcounter` value is `H_TOTAL-1`
- `V_TOTAL`, 525, lines per frame; last `vcounter` value is `V_TOTAL-1`
- `BOX_SIZE`, 32, box edge in pixels
- `STEP`, 2, box motion per frame per axis, in pixels; must divide `H_ACTIVE-BOX_SIZE` and `V_ACTIVE-BOX_SIZE`
- `pixel_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high
- `hcounter`  in  10  current pixel column from the timing controller
- `vcounter`  in  10  current line from the timing controller
- `hsync_in`  in  1  active-low horizontal sync from the timing controller
- `vsync_in`  in  1  active-low vertical sync from the timing controller
- `mode`  in  2  pattern request: 0 colour bars, 1 checkerboard, 2 bouncing box, 3 solid
- `solid_rgb`  in  8  colour for mode 3, packed {R[2:0],G[2:0],B[1:0]}
- `Red`  out  3  pixel red
- `Green`  out  3  pixel green
- `Blue`  out  2  pixel blue
- `Hsync`  out  1  `hsync_in` delayed to align with the RGB outputs
- `Vsync`  out  1  `vsync_in` delayed to align with the RGB outputs
- `frame_count`  out  8  frames completed since reset, wraps 255->0

## Operation
- `frame_tick` is asserted for the single input cycle where `hcounter==H_TOTAL-1` and `vcounter==V_TOTAL-1`.
- **Active mode:** `mode` is sampled into `mode_q` only on `frame_tick`. A mid-frame change takes effect on the next frame's pixel (0,0).
- **Blanking:** if `hcounter>=H_ACTIVE` or `vcounter>=V_ACTIVE`, RGB is 0, regardless of mode.
- **Mode 0, colour bars:** eight 80-px bars. Bar index i = hcounter/80, implemented as a compare chain, with no divider. Let c = 7-i. Then R={3{c[2]}}, G={3{c[1]}}, B={2{c[0]}}. Bar 0 is white; bar 7 is black.
- **Mode 1, checkerboard:** 32-px squares. White (8'hFF) when hcounter[5]^vcounter[5]==0, else black.
- **Mode 2, bouncing box:**
  - Pixels inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE) are white; all others are blue (R=0, G=0, B=3).
- **Box motion (updates only on `frame_tick`, each axis independent):**
  - Moving positive: next = pos+STEP. If next >= limit (limit = H_ACTIVE-BOX_SIZE for x, V_ACTIVE-BOX_SIZE for y), then pos = limit and the direction flips to negative.
  - Moving negative: if pos <= STEP, then pos = 0 and the direction flips to positive; else pos = pos-STEP.
  - The box moves in every mode, not only mode 2.
- **Mode 3, solid:** `solid_rgb` is passed through during the active area. It is sampled every pixel, not frame-latched.
- **Frame counter:** `frame_count` increments on `frame_tick`.
- **Reset values:**
  - RGB = 0
  - `Hsync` = `Vsync` = 1 (inactive)
  - `frame_count` = 0
  - `mode_q` = 0
  - box_x = 304, box_y = 224, both directions positive
- A reset mid-frame restores all of the above on the next edge. Output resumes from the current counter inputs with no resynchronisation.

## Timing
- Latency from (`hcounter`, `vcounter`, `hsync_in`, `vsync_in`) to (RGB, `Hsync`, `Vsync`) is exactly 1 `pixel_clk`, with all five outputs registered in the same stage.
- Box position and `mode_q` become visible on the first pixel after `frame_tick`. That pixel is (0,0), and its output appears 1 cycle later.
- No handshake. The input is a free-running counter, and every cycle produces one output pixel.
- Counter inputs outside the ranges 0..H_TOTAL-1 and 0..V_TOTAL-1 are treated as blanking, and `frame_tick` does not fire.

## Structure
- Shared package `vga_timing_pkg` holds:
  - H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL and the sync-edge constants (656/752, 490/492), shared with the timing controller
  - mode encodings MODE_BARS=0, MODE_CHECK=1, MODE_BOX=2, MODE_SOLID=3
  - BOX_SIZE and STEP defaults
- Sub-module `vga_box_mover` owns the position and direction registers for one axis, parameterised by limit and reset position. It is instantiated twice (x, y) and driven by `frame_tick`.

## Test plan
- **Reset:** hold `reset` 3 cycles with counters running -> RGB=0, Hsync=Vsync=1, frame_count=0, box=(304,224).
- **Colour bars:** mode 0 after one frame, inputs (0,10), (80,10), (639,10), (640,10) -> outputs one cycle later are {7,7,3}, {7,7,0}, {0,0,0}, {0,0,0} (last one blanked).
- **Mode latching:** switch `mode` 0->1 at (320,100) -> bars continue to the end of the frame. At (0,0) of the next frame, checker is white. At (32,0), checker is black.
- **Sync alignment:** drive `hsync_in` low for hcounter 656..751 -> `Hsync` is low for exactly 96 cycles, starting one cycle later. `vsync_in` is checked the same way for lines 490..491.
- **Bounce:** run 152 frames from reset -> box_x=608 with direction negative. The next frame gives box_x=606. `frame_count` wraps to 0 after 256 frames.
- **Solid and reset mid-frame:** mode 3 with solid_rgb=8'hE4 -> R=7, G=1, B=0 in the active area. Assert `reset` at (400,200) -> the next output is RGB=0 and mode_q=0.
